// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared definitions for the RAM fill arbiter slice.
//   STARVE_LIMIT_DEFAULT : default number of back-to-back CPU grants allowed
//                          while a fill beat is waiting.
//   arb_state_t          : fill sequencer states (IDLE, FILL, DONE).
//   starve_cnt_width()   : counter width able to hold 0..limit; never zero,
//                          so a limit of 0 still gets a legal 1-bit counter.
package ram_arb_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  function automatic int starve_cnt_width(input int limit);
    return $clog2(limit + 2);
  endfunction

endpackage

// File: rtl/fill_addr_gen.sv
// fill_addr_gen
// Holds the fill base address and word count captured at launch and steps a
// beat index on every granted fill beat. The address wraps modulo
// 2^ADDR_WIDTH, so a fill may run off the top of the RAM and continue at 0.
// Ports:
//   clk, resetN       : clock, asynchronous active-low reset
//   load              : capture base_in/len_in and restart the index at 0
//   base_in, len_in   : first word address; number of words (0..2^ADDR_WIDTH)
//   advance           : a fill beat was granted this cycle
//   addr              : address of the current (next to be written) beat
//   last_beat         : the current beat is the final one of the fill
module fill_addr_gen #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base_in,
  input  logic [ADDR_WIDTH:0]   len_in,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last_beat
);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   idx_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else if (load) begin
      base_q <= base_in;
      len_q  <= len_in;
      idx_q  <= '0;
    end else if (advance) begin
      idx_q <= idx_q + (ADDR_WIDTH+1)'(1);
    end
  end

  // Dropping the index MSB before the add gives the modulo-2^N wrap for free.
  assign addr = base_q + idx_q[ADDR_WIDTH-1:0];

  // The index is one bit wider than the address so a full-RAM fill
  // (len = 2^ADDR_WIDTH) still finds its last beat.
  assign last_beat = ((idx_q + (ADDR_WIDTH+1)'(1)) == len_q);

endmodule

// File: rtl/ram_fill_arbiter.sv
// ram_fill_arbiter
// Shares a single-port RAM between a CPU and a block-fill engine that writes a
// constant value over a range of words. The CPU normally has priority; the
// fill takes the port whenever the CPU is not asking, or once the CPU has
// been granted STARVE_LIMIT times in a row while a fill beat was waiting.
// Ports:
//   clk, resetN                         : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata               : CPU access request
//   cpu_gnt                             : CPU access performed this cycle
//   cpu_rdata, cpu_rvalid               : read data for last cycle's granted read
//   fill_start/base/len/value           : fill launch pulse and parameters
//   fill_busy, fill_done                : fill in progress; completion pulse
//   ram_addr/we/wdata, ram_rdata        : RAM port A (1-cycle synchronous read)
module ram_fill_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  fill_start,
  input  logic [ADDR_WIDTH-1:0] fill_base,
  input  logic [ADDR_WIDTH:0]   fill_len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int SC_W = starve_cnt_width(STARVE_LIMIT);

  arb_state_t            state_q, state_d;
  logic [SC_W-1:0]       starve_q;
  logic [DATA_WIDTH-1:0] value_q;
  logic                  rvalid_q;

  logic                  load;
  logic                  fill_pending;
  logic                  starved;
  logic                  fill_gnt;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] fill_addr;

  // Launch requests outside IDLE are dropped so a running fill keeps its
  // parameters.
  assign load         = fill_start && (state_q == IDLE);
  assign fill_pending = (state_q == FILL);
  assign starved      = (starve_q == SC_W'(STARVE_LIMIT));

  // resetN gating keeps the CPU off the RAM while reset is held, even though
  // the request path is purely combinational.
  assign cpu_gnt  = resetN && cpu_req && !(fill_pending && starved);
  assign fill_gnt = fill_pending && (!cpu_req || starved);

  fill_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .resetN    (resetN),
    .load      (load),
    .base_in   (fill_base),
    .len_in    (fill_len),
    .advance   (fill_gnt),
    .addr      (fill_addr),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A zero-length fill skips FILL entirely but still produces its done pulse.
  always_comb begin
    state_d   = state_q;
    fill_busy = 1'b0;
    fill_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d = (fill_len == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        fill_busy = 1'b1;
        if (fill_gnt && last_beat) begin
          state_d = DONE;
        end
      end
      DONE: begin
        fill_done = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The starve counter only climbs while a fill beat is actually waiting; it
  // never passes STARVE_LIMIT because at the limit the fill takes the port.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      starve_q <= '0;
      value_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (load) begin
        value_q <= fill_value;
      end
      if (!fill_pending || fill_gnt) begin
        starve_q <= '0;
      end else if (cpu_gnt) begin
        starve_q <= starve_q + SC_W'(1);
      end
      rvalid_q <= cpu_gnt && !cpu_we;
    end
  end

  // Grants are mutually exclusive, so the CPU and the fill can never write
  // the port in the same cycle.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
    end else if (fill_gnt) begin
      ram_addr  = fill_addr;
      ram_we    = 1'b1;
      ram_wdata = value_q;
    end
  end

  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rvalid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_fill_arbiter.sv
// tb_ram_fill_arbiter
// Directed bench for ram_fill_arbiter with a behavioural 1024x16 RAM
// (1-cycle synchronous read) attached to port A. Inputs are driven 1 time
// unit after the rising edge; outputs are compared 1 time unit later.
module tb_ram_fill_arbiter;

  logic        clk;
  logic        resetN;
  logic        cpu_req;
  logic        cpu_we;
  logic [9:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        fill_start;
  logic [9:0]  fill_base;
  logic [10:0] fill_len;
  logic [15:0] fill_value;
  logic        fill_busy;
  logic        fill_done;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  logic [15:0] mem [1024];
  logic [9:0]  exp_wrap [4];

  int checks;
  int failures;

  ram_fill_arbiter #(
    .DATA_WIDTH   (16),
    .ADDR_WIDTH   (10),
    .STARVE_LIMIT (8)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_len   (fill_len),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: read returns the pre-write contents on a collision.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic applyStimulus(input int req, input int we, input int addr,
                               input int wdata, input int fs, input int base,
                               input int len, input int value);
    cpu_req    = 1'(req);
    cpu_we     = 1'(we);
    cpu_addr   = 10'(addr);
    cpu_wdata  = 16'(wdata);
    fill_start = 1'(fs);
    fill_base  = 10'(base);
    fill_len   = 11'(len);
    fill_value = 16'(value);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ft;
    checks   = 0;
    failures = 0;
    exp_wrap = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Reset held with a CPU write requested: nothing may reach the RAM.
    resetN = 1'b0;
    applyStimulus(1, 1, 'h055, 'hBEEF, 0, 0, 0, 0);
    checkOutput("rst_cpu_gnt",   32'(cpu_gnt),    0);
    checkOutput("rst_ram_we",    32'(ram_we),     0);
    checkOutput("rst_ram_addr",  32'(ram_addr),   0);
    checkOutput("rst_ram_wdata", 32'(ram_wdata),  0);
    checkOutput("rst_fill_busy", 32'(fill_busy),  0);
    checkOutput("rst_fill_done", 32'(fill_done),  0);
    checkOutput("rst_rvalid",    32'(cpu_rvalid), 0);
    checkOutput("rst_rdata",     32'(cpu_rdata),  0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetN = 1'b1;
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Wrapping fill of 4 words; a second launch mid-fill must be ignored.
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 'h3FE, 4, 'hA5A5);
    checkOutput("wrap_launch_we",   32'(ram_we),    0);
    checkOutput("wrap_launch_busy", 32'(fill_busy), 0);
    for (int b = 0; b < 4; b++) begin
      nextCycle();
      if (b == 1) applyStimulus(0, 0, 0, 0, 1, 'h100, 1, 'h0F0F);
      else        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("wrap_we",    32'(ram_we),    1);
      checkOutput("wrap_addr",  32'(ram_addr),  32'(exp_wrap[b]));
      checkOutput("wrap_wdata", 32'(ram_wdata), 'hA5A5);
      checkOutput("wrap_busy",  32'(fill_busy), 1);
      checkOutput("wrap_done",  32'(fill_done), 0);
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_done_pulse", 32'(fill_done), 1);
    checkOutput("wrap_done_busy",  32'(fill_busy), 0);
    checkOutput("wrap_done_we",    32'(ram_we),    0);
    nextCycle();
    checkOutput("wrap_after_done", 32'(fill_done), 0);
    checkOutput("wrap_after_busy", 32'(fill_busy), 0);
    checkOutput("wrap_mem_3fe",    32'(mem['h3FE]), 'hA5A5);
    checkOutput("wrap_mem_001",    32'(mem['h001]), 'hA5A5);
    checkOutput("ignored_mem_100", 32'(mem['h100]), 0);

    // CPU write then read back of the same word.
    nextCycle();
    applyStimulus(1, 1, 'h010, 'h1234, 0, 0, 0, 0);
    checkOutput("cpu_wr_gnt",   32'(cpu_gnt),   1);
    checkOutput("cpu_wr_we",    32'(ram_we),    1);
    checkOutput("cpu_wr_addr",  32'(ram_addr),  'h010);
    checkOutput("cpu_wr_wdata", 32'(ram_wdata), 'h1234);
    nextCycle();
    applyStimulus(1, 0, 'h010, 'hFFFF, 0, 0, 0, 0);
    checkOutput("cpu_rd_gnt",    32'(cpu_gnt),    1);
    checkOutput("cpu_rd_we",     32'(ram_we),     0);
    checkOutput("cpu_rd_addr",   32'(ram_addr),   'h010);
    checkOutput("cpu_wr_rvalid", 32'(cpu_rvalid), 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cpu_rd_rvalid", 32'(cpu_rvalid), 1);
    checkOutput("cpu_rd_rdata",  32'(cpu_rdata),  'h1234);
    checkOutput("cpu_idle_gnt",  32'(cpu_gnt),    0);
    nextCycle();
    checkOutput("cpu_rvalid_drop", 32'(cpu_rvalid), 0);
    checkOutput("cpu_rdata_drop",  32'(cpu_rdata),  0);

    // Zero-length fill: done pulse next cycle, no RAM write.
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 'h200, 0, 'hFFFF);
    checkOutput("len0_launch_we", 32'(ram_we), 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("len0_done", 32'(fill_done), 1);
    checkOutput("len0_busy", 32'(fill_busy), 0);
    checkOutput("len0_we",   32'(ram_we),    0);
    nextCycle();
    checkOutput("len0_done_drop", 32'(fill_done), 0);
    checkOutput("len0_mem_200",   32'(mem['h200]), 0);

    // Continuous CPU reads against a 3-word fill: 8 CPU grants then 1 fill beat.
    nextCycle();
    applyStimulus(1, 0, 'h300, 0, 1, 'h020, 3, 'h5A5A);
    checkOutput("starve_launch_gnt", 32'(cpu_gnt), 1);
    for (int i = 0; i < 27; i++) begin
      nextCycle();
      applyStimulus(1, 0, 'h300, 0, 0, 0, 0, 0);
      ft = ((i % 9) == 8) ? 1 : 0;
      checkOutput("starve_cpu_gnt", 32'(cpu_gnt),   1 - ft);
      checkOutput("starve_ram_we",  32'(ram_we),    ft);
      checkOutput("starve_addr",    32'(ram_addr),  (ft == 1) ? ('h020 + i / 9) : 'h300);
      checkOutput("starve_busy",    32'(fill_busy), 1);
    end
    nextCycle();
    applyStimulus(1, 0, 'h300, 0, 0, 0, 0, 0);
    checkOutput("starve_done",     32'(fill_done), 1);
    checkOutput("starve_done_gnt", 32'(cpu_gnt),   1);
    checkOutput("starve_done_busy", 32'(fill_busy), 0);
    checkOutput("starve_mem_022",  32'(mem['h022]), 'h5A5A);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("starve_done_drop", 32'(fill_done), 0);

    // Reset during a 10-word fill after two beats.
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 'h080, 10, 'h1111);
    for (int b = 0; b < 2; b++) begin
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("abort_we",   32'(ram_we),   1);
      checkOutput("abort_addr", 32'(ram_addr), 'h080 + b);
    end
    nextCycle();
    checkOutput("abort_third_addr", 32'(ram_addr), 'h082);
    resetN = 1'b0;
    #1;
    checkOutput("abort_rst_we",   32'(ram_we),    0);
    checkOutput("abort_rst_addr", 32'(ram_addr),  0);
    checkOutput("abort_rst_busy", 32'(fill_busy), 0);
    checkOutput("abort_rst_done", 32'(fill_done), 0);
    repeat (2) begin
      nextCycle();
      checkOutput("abort_hold_done", 32'(fill_done), 0);
      checkOutput("abort_hold_busy", 32'(fill_busy), 0);
    end
    @(negedge clk) resetN = 1'b1;
    repeat (2) begin
      nextCycle();
      checkOutput("abort_post_done", 32'(fill_done), 0);
      checkOutput("abort_post_busy", 32'(fill_busy), 0);
    end
    checkOutput("abort_mem_081", 32'(mem['h081]), 'h1111);
    checkOutput("abort_mem_082", 32'(mem['h082]), 0);

    // A fresh fill after reset runs normally.
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 'h090, 2, 'h2222);
    for (int b = 0; b < 2; b++) begin
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("refill_we",    32'(ram_we),    1);
      checkOutput("refill_addr",  32'(ram_addr),  'h090 + b);
      checkOutput("refill_wdata", 32'(ram_wdata), 'h2222);
    end
    nextCycle();
    checkOutput("refill_done", 32'(fill_done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
